// File: rtl/tone_osc_if.sv
// Connection between the tone lookup and the square-wave oscillator.
// The lookup drives en/period; the oscillator drives the waveform and status.
interface tone_osc_if #(
    parameter int PERIOD_W = 16
);
    // en and period are level signals with no ready: the oscillator samples them
    // only at a waveform-cycle boundary (or in IDLE), and ignores them otherwise.
    logic                en;
    logic [PERIOD_W-1:0] period;
    logic                wave_out;
    logic                cycle_start;
    logic                active;
    logic [PERIOD_W-1:0] active_period;

    modport master (
        output en,
        output period,
        input  wave_out,
        input  cycle_start,
        input  active,
        input  active_period
    );

    modport slave (
        input  en,
        input  period,
        output wave_out,
        output cycle_start,
        output active,
        output active_period
    );
endinterface

// File: rtl/tone_osc.sv
// 50%-duty square-wave oscillator; period changes take effect only at cycle
// boundaries so the output never shows a runt pulse.
module tone_osc #(
    parameter int PERIOD_W   = 16,
    parameter int MIN_PERIOD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    tone_osc_if.slave   bus,
    output logic        state_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);
    localparam logic [PERIOD_W-1:0] MIN_P = PERIOD_W'(MIN_PERIOD);

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] ap_q, ap_d;
    logic                wave_q, wave_d;
    logic                cs_q, cs_d;
    logic                act_q, act_d;

    logic                valid;
    logic [PERIOD_W-1:0] high_len;
    logic [PERIOD_W-1:0] last_cnt;
    logic [PERIOD_W-1:0] cnt_inc;

    assign valid    = bus.en && (bus.period >= MIN_P);
    assign high_len = ap_q - (ap_q >> 1);
    // ap_q >= MIN_PERIOD whenever RUN, so last_cnt never underflows there.
    assign last_cnt = ap_q - ONE;
    assign cnt_inc  = cnt_q + ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ap_d    = ap_q;
        wave_d  = 1'b0;
        cs_d    = 1'b0;
        act_d   = act_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                act_d = 1'b0;
                if (valid) begin
                    state_d = RUN;
                    ap_d    = bus.period;
                    wave_d  = 1'b1;
                    cs_d    = 1'b1;
                    act_d   = 1'b1;
                end
            end
            RUN: begin
                if (cnt_q == last_cnt) begin
                    cnt_d = '0;
                    if (valid) begin
                        ap_d   = bus.period;
                        wave_d = 1'b1;
                        cs_d   = 1'b1;
                    end else begin
                        state_d = IDLE;
                        act_d   = 1'b0;
                    end
                end else begin
                    cnt_d  = cnt_inc;
                    wave_d = (cnt_inc < high_len);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                act_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ap_q    <= '0;
            wave_q  <= 1'b0;
            cs_q    <= 1'b0;
            act_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ap_q    <= ap_d;
            wave_q  <= wave_d;
            cs_q    <= cs_d;
            act_q   <= act_d;
        end
    end

    assign bus.wave_out      = wave_q;
    assign bus.cycle_start   = cs_q;
    assign bus.active        = act_q;
    assign bus.active_period = ap_q;
    assign state_dbg         = (state_q == RUN);

endmodule
